ffe_complex: RTL
================

Name: ffe_complex

Overview:
- Complex (I/Q) fractionally-spaced feed-forward equalizer filter.
- Consumes the flattened tap vectors produced by the LMS tap-update block (o_taps_I/o_taps_Q), and the same input sample stream and shift enable that feed the LMS.
- Produces the equalized complex sample y = sum_k x[k]*w[k] for the downstream slicer/error stage, which closes the loop back to the LMS i_err_I/i_err_Q inputs.

Parameters:
- NUM_TAPS, 11, number of complex taps
- NBT_IN, 8, input sample total bits, S(8,7)
- NBF_IN, 7, input fractional bits
- NBT_TAPS, 28, tap total bits, S(28,25)
- NBF_TAPS, 25, tap fractional bits
- NBT_OUT, 8, output total bits
- NBF_OUT, 7, output fractional bits

Ports:
- clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_is_data_I  in  NBT_IN  input sample, in-phase, signed
- i_is_data_Q  in  NBT_IN  input sample, quadrature, signed
- i_en_shtr  in  1  shift enable; one new sample per asserted cycle
- i_taps_I  in  NUM_TAPS*NBT_TAPS  flattened taps, real part; tap m at [(m+1)*NBT_TAPS-1 : m*NBT_TAPS]
- i_taps_Q  in  NUM_TAPS*NBT_TAPS  flattened taps, imaginary part; same packing
- o_y_I  out  NBT_OUT  equalized output, real part, signed
- o_y_Q  out  NBT_OUT  equalized output, imaginary part, signed
- o_valid  out  1  one-cycle strobe: o_y_I/o_y_Q updated
- o_sat  out  1  saturation occurred on I or Q; qualified by o_valid

Behaviour:
- Clock and reset: single clock clk; reset i_reset is synchronous, active-high.
- Reset values:
  - Delay line, product registers, sum registers: 0.
  - o_y_I = o_y_Q = 0; o_valid = 0; o_sat = 0.
  - Valid pipeline: cleared.
- Delay line: x[0..NUM_TAPS-1], complex.
  - On an edge with i_en_shtr=1: x[0] <= input; x[k] <= x[k-1].
  - i_en_shtr=0: hold.
  - x[0] is the newest sample; tap m multiplies x[m].
- Stage 1, products (registered on the edge after the shift):
  - pr_m = xI[m]*wI[m] - xQ[m]*wQ[m]
  - pi_m = xI[m]*wQ[m] + xQ[m]*wI[m]
  - Full precision: NBT_IN+NBT_TAPS+1 bits, NBF_IN+NBF_TAPS fractional bits.
  - Taps are sampled at this edge; tap changes after it do not affect the sample in flight.
- Stage 2, accumulation:
  - Adder tree over NUM_TAPS products, registered.
  - Guard bits = clog2(NUM_TAPS); no internal overflow allowed.
- Stage 3, output:
  - Truncate (floor, drop LSBs) to NBF_OUT fractional bits.
  - Saturate symmetric-range-free to [-2^(NBT_OUT-1), 2^(NBT_OUT-1)-1].
  - Register o_y_I, o_y_Q, o_sat.
- Latency: sample accepted at edge k (i_en_shtr=1) -> o_valid high during the cycle following edge k+3, o_y reflecting it.
  - Exactly one o_valid pulse per accepted sample.
  - Back-to-back i_en_shtr=1 is fully supported: throughput 1 sample/cycle.
- Idle behaviour: pipeline stages advance only their valid tokens; o_y holds its last value when o_valid=0.
- Mid-operation reset: flushes everything. No o_valid for samples accepted before reset. The first valid after reset is 3 cycles after the first post-reset shift.
- Simultaneous reset and i_en_shtr: reset wins; the sample is dropped.
- Output rate: no decimation in this block; the downstream stage decimates.

Decomposition:
- Shared package ffe_pkg holds:
  - Default width constants: NBT_IN/NBF_IN, NBT_TAPS/NBF_TAPS, NBT_OUT/NBF_OUT, NUM_TAPS.
  - Derived widths: product width, accumulator width.
  - Constant latency FFE_LAT=3, shared with the slicer/LMS alignment logic.
- One sub-module: sat_trunc, signed truncate+saturate with saturation flag. Instantiated twice (I and Q); reused later by the slicer/error stage.

Test Plan:
- Center tap 1.0 (wI[5]=2^25, others 0); input I=64,Q=-32 at shift 0, zeros afterward, en every cycle -> 6th o_valid gives o_y=(64,-32); all other outputs are 0; o_sat=0.
- Rotation: wQ[0]=2^25, all other taps 0; input (32,0) -> o_y=(0,32) exactly 3 cycles after the accepting edge.
- Truncation: wI[0]=2^24 (0.5). Input I=1 -> o_y_I=0; input I=-1 -> o_y_I=-1.
- Saturation: all wI=2^25, input I=127 held for 11 shifts -> o_y_I=127, o_sat=1. Input -128 -> o_y_I=-128, o_sat=1.
- Gating: i_en_shtr asserted every other cycle (LMS-bench cadence) -> one o_valid per shift, fixed latency 3. With i_en_shtr=0 for 5 cycles: no o_valid, o_y stable.
- Reset mid-op: pulse i_reset while 2 samples are in flight -> no o_valid for them; all outputs 0. Next shift produces a valid 3 cycles later using a cleared delay line.

Source files
------------

// File: rtl/ffe_pkg.sv
// Shared constants for the complex feed-forward equalizer and the stages
// that align against it (slicer, error, LMS).
package ffe_pkg;

  localparam int DEF_NUM_TAPS = 11;
  localparam int DEF_NBT_IN   = 8;
  localparam int DEF_NBF_IN   = 7;
  localparam int DEF_NBT_TAPS = 28;
  localparam int DEF_NBF_TAPS = 25;
  localparam int DEF_NBT_OUT  = 8;
  localparam int DEF_NBF_OUT  = 7;

  // One extra bit absorbs the add/subtract of the two partial products.
  localparam int DEF_PROD_W = DEF_NBT_IN + DEF_NBT_TAPS + 1;
  localparam int DEF_PROD_F = DEF_NBF_IN + DEF_NBF_TAPS;
  localparam int DEF_ACC_W  = DEF_PROD_W + $clog2(DEF_NUM_TAPS);

  // Edges from the accepting shift to the registered output.
  localparam int FFE_LAT = 3;

  function automatic int acc_width(input int prod_w, input int num_taps);
    return prod_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/ffe_complex_sat_trunc.sv
// Signed floor-truncate to OUT_F fractional bits, then clamp to OUT_W bits.
module sat_trunc #(
  parameter int IN_W  = 41,
  parameter int IN_F  = 32,
  parameter int OUT_W = 8,
  parameter int OUT_F = 7
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  localparam int SH = IN_F - OUT_F;

  localparam logic signed [IN_W-1:0] MAX_V =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // Arithmetic shift keeps the sign, so dropping LSBs rounds toward -inf.
  assign shifted = i_data >>> SH;

  // Clamp anything outside the output range and flag it.
  always_comb begin
    o_data = shifted[OUT_W-1:0];
    o_sat  = 1'b0;
    if (shifted > MAX_V) begin
      o_data = {1'b0, {(OUT_W-1){1'b1}}};
      o_sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      o_data = {1'b1, {(OUT_W-1){1'b0}}};
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/ffe_complex.sv
// Complex fractionally-spaced FFE: delay line, registered complex products,
// registered sum, registered truncate/saturate. Valid tokens walk alongside.
module ffe_complex
  import ffe_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int NBT_IN   = DEF_NBT_IN,
  parameter int NBF_IN   = DEF_NBF_IN,
  parameter int NBT_TAPS = DEF_NBT_TAPS,
  parameter int NBF_TAPS = DEF_NBF_TAPS,
  parameter int NBT_OUT  = DEF_NBT_OUT,
  parameter int NBF_OUT  = DEF_NBF_OUT
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic signed [NBT_IN-1:0]       i_is_data_I,
  input  logic signed [NBT_IN-1:0]       i_is_data_Q,
  input  logic                           i_en_shtr,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]   i_taps_I,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]   i_taps_Q,
  output logic signed [NBT_OUT-1:0]      o_y_I,
  output logic signed [NBT_OUT-1:0]      o_y_Q,
  output logic                           o_valid,
  output logic                           o_sat
);

  localparam int PROD_W = NBT_IN + NBT_TAPS + 1;
  localparam int PROD_F = NBF_IN + NBF_TAPS;
  localparam int ACC_W  = acc_width(PROD_W, NUM_TAPS);

  function automatic logic signed [PROD_W-1:0] sext_x(input logic signed [NBT_IN-1:0] v);
    return {{(PROD_W-NBT_IN){v[NBT_IN-1]}}, v};
  endfunction

  function automatic logic signed [PROD_W-1:0] sext_w(input logic signed [NBT_TAPS-1:0] v);
    return {{(PROD_W-NBT_TAPS){v[NBT_TAPS-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_p(input logic signed [PROD_W-1:0] v);
    return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

  logic signed [NBT_IN-1:0]   xi_q [NUM_TAPS];
  logic signed [NBT_IN-1:0]   xi_d [NUM_TAPS];
  logic signed [NBT_IN-1:0]   xq_q [NUM_TAPS];
  logic signed [NBT_IN-1:0]   xq_d [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] wi   [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] wq   [NUM_TAPS];
  logic signed [PROD_W-1:0]   pr_i_q [NUM_TAPS];
  logic signed [PROD_W-1:0]   pr_i_d [NUM_TAPS];
  logic signed [PROD_W-1:0]   pr_q_q [NUM_TAPS];
  logic signed [PROD_W-1:0]   pr_q_d [NUM_TAPS];
  logic signed [ACC_W-1:0]    acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]    acc_q_q, acc_q_d;
  logic signed [NBT_OUT-1:0]  y_i_q, y_i_d;
  logic signed [NBT_OUT-1:0]  y_q_q, y_q_d;
  logic                       sat_q, sat_d;
  // bit 0: delay line just shifted, bit FFE_LAT: output register loaded
  logic [FFE_LAT:0]           vld_q, vld_d;
  logic signed [NBT_OUT-1:0]  st_i, st_q;
  logic                       st_sat_i, st_sat_q;

  // Unpack the flattened tap buses; tap m sits at slice m.
  always_comb begin
    for (int m = 0; m < NUM_TAPS; m++) begin
      wi[m] = i_taps_I[m*NBT_TAPS +: NBT_TAPS];
      wq[m] = i_taps_Q[m*NBT_TAPS +: NBT_TAPS];
    end
  end

  // Delay line shift: x[0] takes the new sample, the rest move down by one.
  always_comb begin
    xi_d = xi_q;
    xq_d = xq_q;
    if (i_en_shtr) begin
      xi_d[0] = i_is_data_I;
      xq_d[0] = i_is_data_Q;
      for (int k = 1; k < NUM_TAPS; k++) begin
        xi_d[k] = xi_q[k-1];
        xq_d[k] = xq_q[k-1];
      end
    end
  end

  // Complex products, loaded only for a freshly shifted delay line so the
  // taps are sampled exactly once per sample.
  always_comb begin
    pr_i_d = pr_i_q;
    pr_q_d = pr_q_q;
    if (vld_q[0]) begin
      for (int m = 0; m < NUM_TAPS; m++) begin
        pr_i_d[m] = sext_x(xi_q[m]) * sext_w(wi[m]) - sext_x(xq_q[m]) * sext_w(wq[m]);
        pr_q_d[m] = sext_x(xi_q[m]) * sext_w(wq[m]) + sext_x(xq_q[m]) * sext_w(wi[m]);
      end
    end
  end

  // Sum of products with clog2(NUM_TAPS) guard bits; synthesis balances it
  // into a tree.
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (vld_q[1]) begin
      acc_i_d = '0;
      acc_q_d = '0;
      for (int m = 0; m < NUM_TAPS; m++) begin
        acc_i_d = acc_i_d + sext_p(pr_i_q[m]);
        acc_q_d = acc_q_d + sext_p(pr_q_q[m]);
      end
    end
  end

  sat_trunc #(
    .IN_W (ACC_W),
    .IN_F (PROD_F),
    .OUT_W(NBT_OUT),
    .OUT_F(NBF_OUT)
  ) u_sat_trunc_i (
    .i_data(acc_i_q),
    .o_data(st_i),
    .o_sat (st_sat_i)
  );

  sat_trunc #(
    .IN_W (ACC_W),
    .IN_F (PROD_F),
    .OUT_W(NBT_OUT),
    .OUT_F(NBF_OUT)
  ) u_sat_trunc_q (
    .i_data(acc_q_q),
    .o_data(st_q),
    .o_sat (st_sat_q)
  );

  // Output stage loads only on a valid sum; otherwise the last value holds.
  always_comb begin
    y_i_d = y_i_q;
    y_q_d = y_q_q;
    sat_d = sat_q;
    if (vld_q[2]) begin
      y_i_d = st_i;
      y_q_d = st_q;
      sat_d = st_sat_i | st_sat_q;
    end
  end

  // Valid tokens advance one stage per cycle regardless of new shifts.
  always_comb begin
    vld_d = {vld_q[FFE_LAT-1:0], i_en_shtr};
  end

  // All pipeline state; reset flushes samples in flight and beats a shift.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      xi_q    <= '{default: '0};
      xq_q    <= '{default: '0};
      pr_i_q  <= '{default: '0};
      pr_q_q  <= '{default: '0};
      acc_i_q <= '0;
      acc_q_q <= '0;
      y_i_q   <= '0;
      y_q_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      xi_q    <= xi_d;
      xq_q    <= xq_d;
      pr_i_q  <= pr_i_d;
      pr_q_q  <= pr_q_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      y_i_q   <= y_i_d;
      y_q_q   <= y_q_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end

  assign o_y_I   = y_i_q;
  assign o_y_Q   = y_q_q;
  assign o_sat   = sat_q;
  assign o_valid = vld_q[FFE_LAT];

endmodule
